open_list_select: RTL and testbench

- Open-list store for the A* engine, one stage upstream of the closed-list linear search.
- Holds up to DEPTH candidate nodes (x, y, g, h) and accepts inserts from the neighbour-expansion stage.
- On request, scans linearly for the node with minimum f = g + h and removes it from the list.
- Presents that node (x, y, g, f) downstream, where it becomes the check coordinate for the closed-list search.

---
 rtl/open_list_select.sv | 244 ++++++++++++++++++++++++
 tb/tb_open_list_select.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/open_list_select.sv
// A* open list: stores up to DEPTH (x,y,g,h) nodes and pops the entry with minimum f = g + h (tie: lower h, then lower index).
// Latency: a pop accepted at edge T presents out_valid at edge T+count+2; inserts take one cycle (DUPCHK adds up to count cycles).
// Backpressure: ins_ready drops outside IDLE, at full or under pop_req; OUT holds until out_ready. OPEN_LIST_DUP_UPDATE_EN enables duplicate update.
module open_list_select #(
    parameter int DEPTH  = 400,
    parameter int COST_W = 10,
    parameter int IDX_W  = 9
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [7:0]        ins_x,
    input  logic [7:0]        ins_y,
    input  logic [COST_W-1:0] ins_g,
    input  logic [COST_W-1:0] ins_h,
    input  logic              pop_req,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_x,
    output logic [7:0]        out_y,
    output logic [COST_W-1:0] out_g,
    output logic [COST_W:0]   out_f,
    output logic [IDX_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              underflow
);
    localparam int F_W = COST_W + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SCAN   = 3'd1;
    localparam logic [2:0] S_REMOVE = 3'd2;
    localparam logic [2:0] S_OUT    = 3'd3;
    localparam logic [2:0] S_DUPCHK = 3'd4;

    logic [7:0]        ent_x [DEPTH];
    logic [7:0]        ent_y [DEPTH];
    logic [COST_W-1:0] ent_g [DEPTH];
    logic [COST_W-1:0] ent_h [DEPTH];

    logic [2:0]        state;
    logic [IDX_W-1:0]  scan_idx;
    logic [IDX_W-1:0]  min_idx;
    logic [IDX_W-1:0]  cand_idx;
    logic [IDX_W-1:0]  last_idx;
    logic              rd_active;
    logic              cand_vld;
    logic              cand_better;
    logic [F_W-1:0]    cand_f;
    logic [F_W-1:0]    best_f;
    logic [COST_W-1:0] cand_h;
    logic [COST_W-1:0] best_h;
    logic              ins_fire;
    logic              app_en;
    logic [7:0]        app_x;
    logic [7:0]        app_y;
    logic [COST_W-1:0] app_g;
    logic [COST_W-1:0] app_h;

    assign last_idx  = count - IDX_W'(1);
    assign empty     = (count == '0);
    assign full      = (count == IDX_W'(DEPTH));
    assign ins_ready = (state == S_IDLE) && !full && !pop_req;
    assign ins_fire  = ins_valid && ins_ready;

    // Strict compares keep the earlier index on a full tie.
    assign cand_better = cand_vld &&
                         ((cand_f < best_f) || ((cand_f == best_f) && (cand_h < best_h)));

`ifdef OPEN_LIST_DUP_UPDATE_EN
    logic [7:0]        cap_x;
    logic [7:0]        cap_y;
    logic [COST_W-1:0] cap_g;
    logic [COST_W-1:0] cap_h;
    logic [IDX_W-1:0]  dup_idx;
    logic              dup_hit;
    logic              dup_upd;
    logic              dup_append;

    assign dup_hit    = (state == S_DUPCHK) && (ent_x[dup_idx] == cap_x) && (ent_y[dup_idx] == cap_y);
    assign dup_upd    = dup_hit && (cap_g < ent_g[dup_idx]);
    assign dup_append = (state == S_DUPCHK) && !dup_hit && (dup_idx == last_idx);

    // An empty list has nothing to match, so the insert appends straight from IDLE.
    always_comb begin
        app_en = 1'b0;
        app_x  = ins_x;
        app_y  = ins_y;
        app_g  = ins_g;
        app_h  = ins_h;
        if (ins_fire && empty) begin
            app_en = 1'b1;
        end else if (dup_append) begin
            app_en = 1'b1;
            app_x  = cap_x;
            app_y  = cap_y;
            app_g  = cap_g;
            app_h  = cap_h;
        end
    end
`else
    always_comb begin
        app_en = ins_fire;
        app_x  = ins_x;
        app_y  = ins_y;
        app_g  = ins_g;
        app_h  = ins_h;
    end
`endif

    always_ff @(posedge Clk) begin
        if (app_en) begin
            ent_x[count] <= app_x;
            ent_y[count] <= app_y;
            ent_g[count] <= app_g;
            ent_h[count] <= app_h;
        end else if (state == S_REMOVE) begin
            ent_x[min_idx] <= ent_x[last_idx];
            ent_y[min_idx] <= ent_y[last_idx];
            ent_g[min_idx] <= ent_g[last_idx];
            ent_h[min_idx] <= ent_h[last_idx];
        end
`ifdef OPEN_LIST_DUP_UPDATE_EN
        else if (dup_upd) begin
            ent_g[dup_idx] <= cap_g;
            ent_h[dup_idx] <= cap_h;
        end
`endif
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= S_IDLE;
            count     <= '0;
            out_valid <= 1'b0;
            underflow <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_g     <= '0;
            out_f     <= '0;
            scan_idx  <= '0;
            min_idx   <= '0;
            cand_idx  <= '0;
            rd_active <= 1'b0;
            cand_vld  <= 1'b0;
            cand_f    <= '0;
            cand_h    <= '0;
            best_f    <= '1;
            best_h    <= '1;
`ifdef OPEN_LIST_DUP_UPDATE_EN
            cap_x     <= '0;
            cap_y     <= '0;
            cap_g     <= '0;
            cap_h     <= '0;
            dup_idx   <= '0;
`endif
        end else begin
            underflow <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop_req) begin
                        if (empty) begin
                            underflow <= 1'b1;
                        end else begin
                            state     <= S_SCAN;
                            scan_idx  <= '0;
                            min_idx   <= '0;
                            best_f    <= '1;
                            best_h    <= '1;
                            rd_active <= 1'b1;
                            cand_vld  <= 1'b0;
                        end
                    end else if (ins_fire) begin
`ifdef OPEN_LIST_DUP_UPDATE_EN
                        cap_x <= ins_x;
                        cap_y <= ins_y;
                        cap_g <= ins_g;
                        cap_h <= ins_h;
                        if (empty) begin
                            count <= count + IDX_W'(1);
                        end else begin
                            state   <= S_DUPCHK;
                            dup_idx <= '0;
                        end
`else
                        count <= count + IDX_W'(1);
`endif
                    end
                end
                S_SCAN: begin
                    // Registered read stage ahead of the compare keeps the wide entry mux off the compare path.
                    cand_vld <= rd_active;
                    if (rd_active) begin
                        cand_f   <= F_W'(ent_g[scan_idx]) + F_W'(ent_h[scan_idx]);
                        cand_h   <= ent_h[scan_idx];
                        cand_idx <= scan_idx;
                        if (scan_idx == last_idx) begin
                            rd_active <= 1'b0;
                        end else begin
                            scan_idx <= scan_idx + IDX_W'(1);
                        end
                    end
                    if (cand_better) begin
                        best_f  <= cand_f;
                        best_h  <= cand_h;
                        min_idx <= cand_idx;
                    end
                    if (cand_vld && (cand_idx == last_idx)) begin
                        state <= S_REMOVE;
                    end
                end
                S_REMOVE: begin
                    out_x     <= ent_x[min_idx];
                    out_y     <= ent_y[min_idx];
                    out_g     <= ent_g[min_idx];
                    out_f     <= best_f;
                    count     <= last_idx;
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
`ifdef OPEN_LIST_DUP_UPDATE_EN
                S_DUPCHK: begin
                    if (dup_hit) begin
                        state <= S_IDLE;
                    end else if (dup_idx == last_idx) begin
                        count <= count + IDX_W'(1);
                        state <= S_IDLE;
                    end else begin
                        dup_idx <= dup_idx + IDX_W'(1);
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_open_list_select.sv
// Directed bench for open_list_select: reset, underflow, min-f ordering, tie-break, full, f carry, abort and duplicate update.
module tb_open_list_select;
    logic        Clk;
    logic        Reset;
    logic        ins_valid;
    logic        ins_ready;
    logic [7:0]  ins_x;
    logic [7:0]  ins_y;
    logic [9:0]  ins_g;
    logic [9:0]  ins_h;
    logic        pop_req;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_x;
    logic [7:0]  out_y;
    logic [9:0]  out_g;
    logic [10:0] out_f;
    logic [8:0]  count;
    logic        empty;
    logic        full;
    logic        underflow;

    int checks   = 0;
    int failures = 0;

    open_list_select #(.DEPTH(400), .COST_W(10), .IDX_W(9)) dut (
        .Clk(Clk), .Reset(Reset),
        .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ins_x(ins_x), .ins_y(ins_y), .ins_g(ins_g), .ins_h(ins_h),
        .pop_req(pop_req),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_g(out_g), .out_f(out_f),
        .count(count), .empty(empty), .full(full), .underflow(underflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ins(input logic [7:0] x, input logic [7:0] y, input logic [9:0] g, input logic [9:0] h);
        int w;
        ins_x = x; ins_y = y; ins_g = g; ins_h = h;
        ins_valid = 1'b1;
        tick;
        ins_valid = 1'b0;
        w = 0;
        while (!ins_ready && !full && w < 2000) begin
            tick;
            w++;
        end
    endtask

    task automatic do_pop(input string tag, input int exp_lat, input logic [7:0] ex, input logic [7:0] ey,
                          input logic [9:0] eg, input logic [10:0] ef, input int exp_cnt);
        int lat;
        pop_req = 1'b1;
        tick;
        pop_req = 1'b0;
        lat = 0;
        while (!out_valid && lat < 2000) begin
            tick;
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_x"}, out_x, ex);
        chk({tag, "_y"}, out_y, ey);
        chk({tag, "_g"}, out_g, eg);
        chk({tag, "_f"}, out_f, ef);
        chk({tag, "_count"}, count, exp_cnt);
        if (out_ready) begin
            tick;
            chk({tag, "_valid_drop"}, out_valid, 0);
        end
    endtask

    task automatic pulse_reset;
        Reset = 1'b1;
        #3;
        Reset = 1'b0;
        tick;
    endtask

    initial begin
        Reset = 1'b1;
        ins_valid = 1'b0; ins_x = '0; ins_y = '0; ins_g = '0; ins_h = '0;
        pop_req = 1'b0; out_ready = 1'b1;
        #12;
        Reset = 1'b0;
        tick;

        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_x", out_x, 0);
        chk("rst_out_f", out_f, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_ins_ready", ins_ready, 1);

        pop_req = 1'b1;
        tick;
        pop_req = 1'b0;
        chk("uf_pulse", underflow, 1);
        chk("uf_out_valid", out_valid, 0);
        chk("uf_count", count, 0);
        tick;
        chk("uf_clear", underflow, 0);

        ins(8'd3, 8'd4, 10'd5, 10'd7);
        ins(8'd1, 8'd1, 10'd2, 10'd2);
        ins(8'd9, 8'd9, 10'd10, 10'd0);
        chk("ins3_count", count, 3);
        do_pop("pop1", 5, 8'd1, 8'd1, 10'd2, 11'd4, 2);
        do_pop("pop2", 4, 8'd9, 8'd9, 10'd10, 11'd10, 1);
        do_pop("pop3", 3, 8'd3, 8'd4, 10'd5, 11'd12, 0);
        chk("pop3_empty", empty, 1);

        ins(8'd5, 8'd5, 10'd6, 10'd4);
        ins(8'd6, 8'd6, 10'd8, 10'd2);
        ins(8'd7, 8'd7, 10'd8, 10'd2);
        do_pop("tie", 5, 8'd6, 8'd6, 10'd8, 11'd10, 2);

        pulse_reset;
        chk("rst2_count", count, 0);
        ins(8'h11, 8'h22, 10'd1023, 10'd1023);
        do_pop("carry", 3, 8'h11, 8'h22, 10'd1023, 11'd2046, 0);

        ins(8'd1, 8'd2, 10'd3, 10'd4);
        ins(8'd2, 8'd3, 10'd4, 10'd5);
        pop_req = 1'b1;
        tick;
        pop_req = 1'b0;
        tick;
        Reset = 1'b1;
        #2;
        chk("abort_count", count, 0);
        chk("abort_valid", out_valid, 0);
        Reset = 1'b0;
        tick;
        chk("abort_ins_ready", ins_ready, 1);

`ifndef OPEN_LIST_DUP_UPDATE_EN
        for (int i = 0; i < 400; i++) begin
            ins(8'(i), 8'(i >> 8), 10'(1000 - i), 10'd5);
        end
        chk("fill_count", count, 400);
        chk("fill_full", full, 1);
        chk("fill_ins_ready", ins_ready, 0);
        ins_valid = 1'b1;
        tick;
        ins_valid = 1'b0;
        chk("fill_blocked", count, 400);
        out_ready = 1'b0;
        do_pop("full_pop", 402, 8'd143, 8'd1, 10'd601, 11'd606, 399);
        chk("full_pop_notfull", full, 0);
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("hold_valid", out_valid, 1);
            chk("hold_x", out_x, 143);
            chk("hold_f", out_f, 606);
        end
        out_ready = 1'b1;
        tick;
        chk("hold_release", out_valid, 0);
        chk("hold_count", count, 399);
`endif

`ifdef OPEN_LIST_DUP_UPDATE_EN
        pulse_reset;
        ins(8'd2, 8'd2, 10'd9, 10'd3);
        ins(8'd2, 8'd2, 10'd4, 10'd3);
        ins(8'd2, 8'd2, 10'd8, 10'd3);
        chk("dup_count", count, 1);
        do_pop("dup_pop", 3, 8'd2, 8'd2, 10'd4, 11'd7, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
